pulse_burst_tx: RTL and testbench

Transmit-side companion to the team's modulo-5 pulse-counting FSM. It accepts a burst length via a valid/ready handshake and drives that many single-cycle pulses on one line, separated by a programmable idle gap. It also keeps a running modulo tally so that its wrap flag asserts in the same cycle the downstream counter reaches its terminal state. It sits directly in front of the counter's pulse input, in a bench or as a stimulus source.

---
 rtl/pulse_burst_tx.sv | 86 ++++++++
 tb/tb_pulse_burst_tx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_burst_tx.sv
// Burst pulse generator: sends start_count single-cycle pulses spaced by GAP idle cycles, with a modulo-MOD tally.
// Latency: first pulse in the cycle after the handshake, done one cycle after the last pulse.
// Backpressure: start_ready is high only in IDLE; requests seen in any other state are dropped, not queued.
module pulse_burst_tx #(
    parameter int GAP = 1,
    parameter int MOD = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_valid,
    input  logic [2:0] start_count,
    output logic       start_ready,
    output logic       pulse_out,
    output logic       busy,
    output logic       done,
    output logic       wrap,
    output logic [2:0] tally
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] TALLY_TOP = 3'(MOD - 1);
    localparam logic [3:0] GAP_LOAD  = 4'(GAP - 1);

    logic [1:0] state;
    logic [2:0] remaining;
    logic [3:0] gap_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            remaining <= 3'd0;
            gap_cnt   <= 4'd0;
            tally     <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_valid) begin
                        if (start_count == 3'd0) begin
                            state <= S_DONE;
                        end else begin
                            remaining <= start_count;
                            state     <= S_PULSE;
                        end
                    end
                end
                S_PULSE: begin
                    remaining <= remaining - 3'd1;
                    tally     <= (tally == TALLY_TOP) ? 3'd0 : tally + 3'd1;
                    if (remaining == 3'd1) begin
                        state <= S_DONE;
                    end else if (GAP == 0) begin
                        state <= S_PULSE;
                    end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= S_PULSE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // All outputs decode from registers only, so nothing flows combinationally from the inputs.
    assign start_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign pulse_out   = (state == S_PULSE);
    assign done        = (state == S_DONE);
    assign wrap        = (state == S_PULSE) && (tally == TALLY_TOP);

endmodule

// File: tb/tb_pulse_burst_tx.sv
// Bench for pulse_burst_tx: three parameterisations driven by directed and random bursts against a schedule model.
module tb_pulse_burst_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] sv = 3'b000;
    logic [2:0] sc [3];
    logic [2:0] rdy, po, bz, dn, wr;
    logic [2:0] ta [3];

    int gap_of [3] = '{1, 0, 3};
    int mod_of [3] = '{5, 3, 8};
    int m_tally [3];
    int m_sent [3];
    int cnt_seen [3];

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pulse_burst_tx #(.GAP(1), .MOD(5)) dut_a (
        .clk(clk), .reset(reset), .start_valid(sv[0]), .start_count(sc[0]),
        .start_ready(rdy[0]), .pulse_out(po[0]), .busy(bz[0]), .done(dn[0]),
        .wrap(wr[0]), .tally(ta[0])
    );
    pulse_burst_tx #(.GAP(0), .MOD(3)) dut_b (
        .clk(clk), .reset(reset), .start_valid(sv[1]), .start_count(sc[1]),
        .start_ready(rdy[1]), .pulse_out(po[1]), .busy(bz[1]), .done(dn[1]),
        .wrap(wr[1]), .tally(ta[1])
    );
    pulse_burst_tx #(.GAP(3), .MOD(8)) dut_c (
        .clk(clk), .reset(reset), .start_valid(sv[2]), .start_count(sc[2]),
        .start_ready(rdy[2]), .pulse_out(po[2]), .busy(bz[2]), .done(dn[2]),
        .wrap(wr[2]), .tally(ta[2])
    );

    // Downstream counter stand-in: counts every pulse each instance emits.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) cnt_seen[i] <= 0;
        end else begin
            for (int i = 0; i < 3; i++) if (po[i]) cnt_seen[i] <= cnt_seen[i] + 1;
        end
    end

    task automatic chk(input string tag, input int s, input logic [31:0] obs, input int exp);
        n_assert++;
        assert (obs === 32'(exp)) else begin
            n_fail++;
            $error("FAIL %s[dut%0d] observed=%0d expected=%0d", tag, s, obs, exp);
        end
    endtask

    // Entered at a negedge in an IDLE cycle; returns at the negedge of the cycle where start_ready is back.
    task automatic run_burst(input int s, input int n, input bit hold);
        int g;
        int len;
        bit p;
        g = gap_of[s];
        len = (n == 0) ? 0 : n + (n - 1) * g;
        sv[s] = 1'b1;
        sc[s] = 3'(n);
        chk("rdy_before", s, 32'(rdy[s]), 1);
        @(negedge clk);
        if (!hold) sv[s] = 1'b0;
        for (int c = 1; c <= len; c++) begin
            p = ((c - 1) % (g + 1)) == 0;
            chk("pulse", s, 32'(po[s]), int'(p));
            chk("wrap", s, 32'(wr[s]), int'(p && (m_tally[s] == mod_of[s] - 1)));
            chk("tally_mid", s, 32'(ta[s]), m_tally[s]);
            chk("busy_mid", s, 32'(bz[s]), 1);
            chk("rdy_mid", s, 32'(rdy[s]), 0);
            chk("done_early", s, 32'(dn[s]), 0);
            if (p) begin
                m_tally[s] = (m_tally[s] + 1) % mod_of[s];
                m_sent[s]++;
            end
            @(negedge clk);
        end
        chk("done", s, 32'(dn[s]), 1);
        chk("busy_done", s, 32'(bz[s]), 1);
        chk("rdy_done", s, 32'(rdy[s]), 0);
        chk("pulse_done", s, 32'(po[s]), 0);
        @(negedge clk);
        chk("rdy_after", s, 32'(rdy[s]), 1);
        chk("busy_after", s, 32'(bz[s]), 0);
        chk("done_after", s, 32'(dn[s]), 0);
        chk("tally_after", s, 32'(ta[s]), m_tally[s]);
        chk("pulses_seen", s, 32'(cnt_seen[s]), m_sent[s]);
    endtask

    initial begin
        int s;
        int n;
        bit h;
        for (int i = 0; i < 3; i++) begin
            sc[i] = 3'd0;
            m_tally[i] = 0;
            m_sent[i] = 0;
        end

        // Reset values
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_pulse", i, 32'(po[i]), 0);
            chk("rst_busy", i, 32'(bz[i]), 0);
            chk("rst_done", i, 32'(dn[i]), 0);
            chk("rst_wrap", i, 32'(wr[i]), 0);
            chk("rst_rdy", i, 32'(rdy[i]), 1);
            chk("rst_tally", i, 32'(ta[i]), 0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Burst of 3 then 4 on GAP=1/MOD=5: wrap on 5th pulse overall, tally 3 then 2
        run_burst(0, 3, 1'b0);
        chk("tally_after_3", 0, 32'(ta[0]), 3);
        @(negedge clk);
        run_burst(0, 4, 1'b0);
        chk("tally_after_3p4", 0, 32'(ta[0]), 2);
        chk("seen_7", 0, 32'(cnt_seen[0]), 7);

        // Zero-length burst
        run_burst(0, 0, 1'b0);
        chk("tally_zero_len", 0, 32'(ta[0]), 2);

        // GAP=0, seven back-to-back pulses
        run_burst(1, 7, 1'b0);

        // start_valid held across two bursts
        run_burst(0, 2, 1'b1);
        run_burst(0, 3, 1'b1);
        sv[0] = 1'b0;
        @(negedge clk);

        // Randomized bursts across all instances
        for (int it = 0; it < 24; it++) begin
            s = $urandom_range(0, 2);
            n = $urandom_range(0, 7);
            h = 1'($urandom_range(0, 1));
            run_burst(s, n, h);
            sv[s] = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during the 2nd pulse of a 5-pulse burst on GAP=1
        @(negedge clk);
        sv[0] = 1'b1;
        sc[0] = 3'd5;
        @(negedge clk);
        sv[0] = 1'b0;
        chk("rb_p1", 0, 32'(po[0]), 1);
        @(negedge clk);
        chk("rb_gap", 0, 32'(po[0]), 0);
        @(negedge clk);
        chk("rb_p2", 0, 32'(po[0]), 1);
        #2 reset = 1'b0;
        #1;
        chk("rb_pulse_drop", 0, 32'(po[0]), 0);
        chk("rb_done", 0, 32'(dn[0]), 0);
        chk("rb_tally", 0, 32'(ta[0]), 0);
        chk("rb_rdy", 0, 32'(rdy[0]), 1);
        chk("rb_busy", 0, 32'(bz[0]), 0);
        @(negedge clk);
        chk("rb_hold_pulse", 0, 32'(po[0]), 0);
        chk("rb_hold_done", 0, 32'(dn[0]), 0);
        chk("rb_hold_tally", 0, 32'(ta[0]), 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_tally[i] = 0;
            m_sent[i] = 0;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rb_after_pulse", 0, 32'(po[0]), 0);
            chk("rb_after_done", 0, 32'(dn[0]), 0);
            chk("rb_after_rdy", 0, 32'(rdy[0]), 1);
        end
        run_burst(0, 6, 1'b0);
        chk("rb_recover_tally", 0, 32'(ta[0]), 1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
